// File: rtl/ssd_reader.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus and
// presents the assembled word once every digit position has been captured.
module ssd_reader #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic                  valid,
  output logic                  err
);

  localparam int unsigned SW = 7 + DIGITS;
  localparam int unsigned CW = 4;
  localparam int unsigned VW = 4 * DIGITS;

  logic [SW-1:0]     sync1, sync2;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DIGITS-1:0] seen, seen_nxt;
  logic [VW-1:0]     slots, slots_nxt, value_nxt;
  logic              valid_nxt, err_nxt;

  logic              same_c, capture_c, onehot_c, legal_c;
  logic [DIGITS-1:0] en_c;
  logic [3:0]        nib_c;

  // Glyph to nibble; returns {legal, nibble}
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'b0_0000;
    case (pat)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // sync1 is the freshly synchronized sample, sync2 the previous one
  assign same_c    = (sync1 == sync2);
  assign capture_c = same_c && (cnt == CW'(STABLE - 1));
  assign en_c      = ~sync2[SW-1:7];
  assign onehot_c  = (en_c != '0) && ((en_c & (en_c - DIGITS'(1))) == '0);
  assign {legal_c, nib_c} = decode(~sync2[6:0]);

  always_comb begin
    cnt_nxt = cnt;
    if (!same_c)
      cnt_nxt = CW'(1);
    else if (cnt != CW'(STABLE))
      cnt_nxt = cnt + CW'(1);
  end

  // Slot update and frame assembly on a qualified capture
  always_comb begin
    slots_nxt = slots;
    seen_nxt  = seen;
    value_nxt = value;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (capture_c && onehot_c) begin
      if (legal_c) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (en_c[i]) begin
            slots_nxt[4*i +: 4] = nib_c;
            seen_nxt[i]         = 1'b1;
          end
        end
        if (&seen_nxt) begin
          value_nxt = slots_nxt;
          valid_nxt = 1'b1;
          seen_nxt  = '0;
        end
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      cnt   <= '0;
      seen  <= '0;
      slots <= '0;
      value <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      sync1 <= {an_n, seg_n};
      sync2 <= sync1;
      cnt   <= cnt_nxt;
      seen  <= seen_nxt;
      slots <= slots_nxt;
      value <= value_nxt;
      valid <= valid_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_reader.sv
// Bench for ssd_reader: a run-length/table model checked every cycle, plus
// directed scans with hand-computed frame values and pulse timing.
module tb_ssd_reader;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 4;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] value;
  logic        valid, err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int last_valid_cyc = -1;

  ssd_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
    .value(value), .valid(valid), .err(err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a capture happens when exactly STABLE identical samples precede this edge
  logic [10:0] q[$];
  logic [3:0]  m_slot [4];
  logic [3:0]  m_seen;
  logic [15:0] m_value;
  logic        m_valid, m_err;

  always begin
    @(posedge clk);
    cyc++;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
      m_seen  = 4'h0;
      m_value = 16'h0;
    end else begin
      int n;
      bit run;
      n = q.size();
      run = (n >= int'(STABLE));
      if (run) begin
        for (int i = 1; i < int'(STABLE); i++)
          if (q[n-1-i] != q[n-1]) run = 0;
        if (n > int'(STABLE) && q[n-1-STABLE] == q[n-1]) run = 0;
      end
      if (run && $countones(~q[n-1][10:7]) == 1) begin
        int k, d;
        logic [3:0]  sel;
        logic [6:0]  pat;
        sel = ~q[n-1][10:7];
        pat = ~q[n-1][6:0];
        k = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) k = i;
        d = -1;
        for (int g = 0; g < 16; g++) if (GLYPH[g] == pat) d = g;
        if (d < 0) m_err = 1'b1;
        else begin
          m_slot[k] = 4'(d);
          m_seen[k] = 1'b1;
          if (m_seen == 4'hF) begin
            m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_valid = 1'b1;
            m_seen  = 4'h0;
          end
        end
      end
      q.push_back({an_n, seg_n});
      if (q.size() > int'(STABLE) + 1) void'(q.pop_front());
    end
    #1;
    if (valid) begin vcnt++; last_valid_cyc = cyc; end
    if (err) ecnt++;
    check("cycle_outputs", {14'h0, value, valid, err}, {14'h0, m_value, m_valid, m_err});
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] pat, input int n);
    an_n  = an;
    seg_n = ~pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input int k, input int d);
    drive(4'(~(4'b0001 << k)), GLYPH[d], 8);
  endtask

  initial begin
    int v0, e0, c0;
    repeat (3) @(negedge clk);
    check("reset_value", {16'h0, value}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    rst_n = 1'b1;
    drive(4'hF, 7'h00, 6);

    // Basic frame 0x1234
    v0 = vcnt;
    put(0, 4); put(1, 3); put(2, 2);
    check("basic_no_early_valid", vcnt - v0, 0);
    put(3, 1);
    check("basic_valid_count", vcnt - v0, 1);
    check("basic_value", {16'h0, value}, 32'h1234);

    // Stability filter on digit 0: short 0 glitch then 8
    v0 = vcnt;
    put(1, 3); put(2, 2); put(3, 1);
    drive(4'b1110, 7'h3F, 3);
    c0 = cyc;
    drive(4'b1110, 7'h7F, 10);
    check("filter_valid_count", vcnt - v0, 1);
    check("filter_capture_edge", last_valid_cyc - c0, 5);
    check("filter_value", {16'h0, value}, 32'h1238);

    // Illegal glyph and ambiguous selection
    v0 = vcnt; e0 = ecnt;
    put(0, 5); put(1, 6); put(3, 7);
    drive(4'b1011, 7'h00, 8);
    check("illegal_err_count", ecnt - e0, 1);
    check("illegal_no_valid", vcnt - v0, 0);
    drive(4'b1100, GLYPH[1], 8);
    check("ambiguous_no_err", ecnt - e0, 1);
    check("ambiguous_no_valid", vcnt - v0, 0);
    put(2, 9);
    check("illegal_frame_valid", vcnt - v0, 1);
    check("illegal_frame_value", {16'h0, value}, 32'h7965);

    // Overwrite and free scan order
    v0 = vcnt;
    put(3, 12); put(1, 14); put(1, 10); put(0, 13);
    check("order_no_early_valid", vcnt - v0, 0);
    put(2, 11);
    check("order_valid_count", vcnt - v0, 1);
    check("order_value", {16'h0, value}, 32'hCBAD);

    // Back-to-back frames
    v0 = vcnt;
    put(0, 4); put(1, 3); put(2, 2); put(3, 1);
    check("b2b_first_value", {16'h0, value}, 32'h1234);
    put(0, 15); put(1, 14); put(2, 14);
    check("b2b_seen_cleared", vcnt - v0, 1);
    put(3, 11);
    check("b2b_valid_count", vcnt - v0, 2);
    check("b2b_second_value", {16'h0, value}, 32'hBEEF);

    // Reset mid-frame discards partial state
    put(0, 1);
    drive(4'b1101, GLYPH[2], 2);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_value", {16'h0, value}, 32'h0);
    check("midreset_valid", {31'h0, valid}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    v0 = vcnt;
    drive(4'b1101, GLYPH[2], 8);
    put(2, 3); put(3, 4);
    check("midreset_partial_dropped", vcnt - v0, 0);
    check("midreset_value_held", {16'h0, value}, 32'h0);
    put(0, 5);
    check("midreset_frame_valid", vcnt - v0, 1);
    check("midreset_frame_value", {16'h0, value}, 32'h4325);

    drive(4'hF, 7'h00, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_reader.md
# ssd_reader

Recovers hex digits from a multiplexed, active-low seven-segment display bus: active-low segment lines plus one-hot-low digit enables. It is the receive-side counterpart to our hex-to-segment encoding. Display-bus signals are synchronized and must hold stable before a digit is accepted. Each glyph is decoded back to a nibble, and once every digit position has been seen, the block presents the assembled word with a one-cycle valid pulse. It sits between board display pins (or a display-driver model) and the checking and readback logic.

## Interface

- DIGITS, 4: number of multiplexed digit positions.
- STABLE, 4: consecutive identical synchronized samples required before capture; legal range 2..15.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg_n  in  7  active-low segments; bit0=a … bit6=g; asynchronous to clk.
- an_n  in  DIGITS  active-low digit enables; bit k selects position k; asynchronous to clk.
- value  out  4*DIGITS  last complete frame; digit k is in value[4k+3:4k].
- valid  out  1  one-cycle pulse when value is updated.
- err  out  1  one-cycle pulse when a stable, selected glyph is not one of the 16 legal codes.

## Operation

- Synchronizer: two flops on {seg_n, an_n}. Reset value is all ones: segments dark, no digit selected.
- Stability counter:
  - Compares the synchronized sample with the previous synchronized sample.
  - Differ: counter = 1.
  - Equal: counter increments, saturating at STABLE.
- Capture event: the counter reaches STABLE this cycle. There is exactly one event per stable interval, so holding a pattern longer never recaptures it.
- At a capture event, the block acts only if an_n has exactly one bit low (position k).
  - an_n all ones or more than one bit low: event ignored, no err.
- Glyph decode:
  - Invert seg_n to get the active-high pattern.
  - Match against 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, B:7C, C:39, D:5E, E:79, F:71.
  - Match: slot k gets the nibble, and seen[k] is set.
  - No match: err pulses; slot k and seen[k] are unchanged.
- Repeat capture of a digit already seen in the current frame overwrites slot k.
- Frame completion: after a capture, if all seen bits are 1:
  - value is loaded from all slots, including the nibble captured in this same cycle.
  - valid pulses.
  - seen clears to 0.
  - Slot contents are retained.
- value holds between frames. Partial frames never reach value.
- Scan order is free; any order completes the frame.

## Timing

- Reset (async assert): value=0, valid=0, err=0, seen=0, counter=0, slots=0, synchronizer=all ones. Deassertion is assumed synchronized externally.
- Capture latency: an input change first sampled at edge 1 is captured at edge STABLE+1. For STABLE=4, capture is at edge 5.
- valid and value update at the same edge as the final capture of a frame. err is registered at its capture edge.
- valid and err are never both high: a frame completes only on a legal capture.
- A glitch shorter than STABLE synchronized cycles produces no capture. The counter restarts from 1 on the following pattern.
- Reset mid-frame discards all partial state, and value returns to 0.

## Test plan

- Reset: assert rst_n=0 mid-frame, then release → value=0x0000, valid=0, err=0. The next full scan is required to produce a frame.
- Basic frame: hold each pattern 8 cycles: an_n=1110/seg_n=~0x66, 1101/~0x4F, 1011/~0x5B, 0111/~0x06 → one valid pulse at capture of digit 3, value=0x1234.
- Stability filter: STABLE=4; an_n=1110, seg_n=~0x3F for 3 cycles, then ~0x7F held 10 cycles → single capture of 8 at edge 5 after the change, no capture of 0.
- Illegal/ambiguous: seg_n=~0x00 on digit 2 → err pulses once, no valid. an_n=1100 with a legal glyph → no capture, no err. Frame completes only after a legal digit 2 is captured.
- Overwrite and order: scan 3,1,1(new glyph A),0,2 → valid once after digit 2; slot 1 holds A.
- Back-to-back frames: two full scans, 0x1234 then 0xBEEF → two valid pulses; value tracks each, and seen clears between frames.
